// File: rtl/hop_launch_sched.sv
// Hop-chain launch scheduler: sequenced chain resets, round-robin launch grants, tail-arrival check.
// Optional macro HOP_ERR_STICKY_EN makes err sticky until err_clr; otherwise err is a one-cycle pulse.
module hop_launch_sched #(
  parameter int NCH      = 4,
  parameter int HOPS     = 5,
  parameter int RST_CYC  = 4,
  parameter int TO_EXTRA = 2
) (
  input  logic                  clock0,
  input  logic                  rst1,
  input  logic                  en,
  input  logic [NCH-1:0]        req,
  output logic [NCH-1:0]        grant,
  output logic [NCH-1:0]        start,
  output logic [NCH*HOPS-1:0]   stage_rst,
  input  logic [NCH-1:0]        chain_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr,
  output logic [$clog2(NCH)-1:0] last_ch
);

  localparam int LW   = $clog2(NCH);
  localparam int TMAX = HOPS + TO_EXTRA;
  // The counter is shared by reset hold, release and wait, so it must cover the longest of them.
  localparam int CMAX = (TMAX > RST_CYC) ? TMAX : RST_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RELEASE,
    S_ARMED,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [LW-1:0]       r_last_ch, w_last_nxt, w_pick;
  logic [NCH-1:0]      r_start, w_grant;
  logic [NCH*HOPS-1:0] r_stage_rst, w_stage_nxt;
  logic                r_done, r_err;
  logic                w_found, w_ok, w_fail;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!w_found && req[(int'(r_last_ch) + i) % NCH]) begin
        w_found = 1'b1;
        w_pick  = LW'((int'(r_last_ch) + i) % NCH);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last_ch;
    w_grant     = '0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      S_RST_HOLD: begin
        if (r_cnt == CW'(RST_CYC - 1)) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (r_cnt == CW'(HOPS - 1)) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ARMED: begin
        if (en && w_found) begin
          w_grant[w_pick] = 1'b1;
          w_last_nxt      = w_pick;
          w_state_nxt     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = CW'(1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Any arrival ends the transaction; only an arrival exactly HOPS cycles after start is good.
        if (chain_out[r_last_ch]) begin
          w_ok        = (r_cnt == CW'(HOPS));
          w_fail      = (r_cnt != CW'(HOPS));
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(TMAX)) begin
          w_fail      = 1'b1;
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_RST_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stage resets are registered from the next state so they never glitch; hop h releases in release cycle h.
  always_comb begin
    w_stage_nxt = '0;
    if (w_state_nxt == S_RST_HOLD) begin
      w_stage_nxt = '1;
    end else if (w_state_nxt == S_RELEASE) begin
      for (int c = 0; c < NCH; c++) begin
        for (int h = 0; h < HOPS; h++) begin
          w_stage_nxt[c*HOPS + h] = (h > int'(w_cnt_nxt));
        end
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      r_state     <= S_RST_HOLD;
      r_cnt       <= '0;
      r_last_ch   <= LW'(NCH - 1);
      r_start     <= '0;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_ch   <= w_last_nxt;
      r_start     <= w_grant;
      r_stage_rst <= w_stage_nxt;
      r_done      <= w_ok;
`ifdef HOP_ERR_STICKY_EN
      if (w_fail) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
`else
      r_err <= w_fail;
`endif
    end
  end

`ifndef HOP_ERR_STICKY_EN
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
`endif

  assign grant     = w_grant;
  assign start     = r_start;
  assign stage_rst = r_stage_rst;
  assign busy      = (r_state != S_ARMED);
  assign done      = r_done;
  assign err       = r_err;
  assign last_ch   = r_last_ch;

endmodule

// File: tb/tb_hop_launch_sched.sv
// Bench for hop_launch_sched: directed reset/round-robin/timeout/early/abort sequences plus random traffic
// against a transaction-level model; the chain datapath is modelled as per-chain delay lines.
module tb_hop_launch_sched;

  localparam int NCH      = 4;
  localparam int HOPS     = 5;
  localparam int RST_CYC  = 4;
  localparam int TO_EXTRA = 2;
  localparam int TMAX     = HOPS + TO_EXTRA;

  logic                clock0 = 1'b0;
  logic                rst1, en, errClr;
  logic [NCH-1:0]      req, grant, start, chainOut;
  logic [NCH*HOPS-1:0] stageRst;
  logic                busy, done, err;
  logic [1:0]          lastCh;

  always #5 clock0 = ~clock0;

  hop_launch_sched #(.NCH(NCH), .HOPS(HOPS), .RST_CYC(RST_CYC), .TO_EXTRA(TO_EXTRA)) dut (
    .clock0(clock0), .rst1(rst1), .en(en), .req(req), .grant(grant), .start(start),
    .stage_rst(stageRst), .chain_out(chainOut), .busy(busy), .done(done), .err(err),
    .err_clr(errClr), .last_ch(lastCh)
  );

  // Chain of chainLen flops (0 = token lost); flops honour their stage reset.
  logic [HOPS-1:0] pipe [NCH];
  int              chainLen [NCH];

  always @(posedge clock0) begin
    for (int c = 0; c < NCH; c++) begin
      for (int h = 0; h < HOPS; h++) begin
        if (stageRst[c*HOPS + h] || h >= chainLen[c]) pipe[c][h] <= 1'b0;
        else if (h == 0) pipe[c][h] <= start[c];
        else pipe[c][h] <= pipe[c][h-1];
      end
    end
  end

  always_comb begin
    chainOut = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chainLen[c] > 0) chainOut[c] = pipe[c][chainLen[c]-1];
    end
  end

  typedef struct {
    int              cyc;
    logic [HOPS-1:0] hopMask;
    logic            busyExp;
  } resetVec_t;

  resetVec_t      vecTab [10];
  int             k, mFree, mLast, evStart, evStartCh, evDone, evErr, forceLat;
  logic           stickyHeld;
  logic [NCH-1:0] dropPend;
  int             nVec = 0, nFail = 0;
  int             grantLog [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  function automatic logic [NCH*HOPS-1:0] expStage(input int cyc);
    logic [HOPS-1:0] m;
    for (int h = 0; h < HOPS; h++) begin
      if (cyc < RST_CYC) m[h] = 1'b1;
      else if (cyc < RST_CYC + HOPS) m[h] = (h > cyc - RST_CYC);
      else m[h] = 1'b0;
    end
    return {NCH{m}};
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] raise, input logic enVal, input logic clrVal);
    req      = (req & ~dropPend) | (raise & ~dropPend);
    dropPend = '0;
    en       = enVal;
    errClr   = clrVal;
  endtask

  task automatic doReset();
    rst1 = 1'b1; req = '0; en = 1'b0; errClr = 1'b0; dropPend = '0;
    repeat (2) @(posedge clock0);
    @(negedge clock0);
    rst1 = 1'b0;
    k = 0; mFree = RST_CYC + HOPS; mLast = NCH - 1;
    evStart = -1; evStartCh = 0; evDone = -1; evErr = -1; stickyHeld = 1'b0;
  endtask

  // One cycle: compare every output against the model, advance the model, move to next negedge.
  task automatic cycleCheck();
    int             g, len;
    logic [NCH-1:0] expGrant, expStart;
    logic           expErr;
    #1;
    g = -1;
    if (k >= mFree && en && (|req)) begin
      for (int i = 1; i <= NCH; i++) begin
        if (g < 0 && req[(mLast + i) % NCH]) g = (mLast + i) % NCH;
      end
    end
    expGrant = '0;
    if (g >= 0) expGrant[g] = 1'b1;
    expStart = '0;
    if (k == evStart) expStart[evStartCh] = 1'b1;
`ifdef HOP_ERR_STICKY_EN
    expErr = (k == evErr) || stickyHeld;
    stickyHeld = expErr && !errClr;
`else
    expErr = (k == evErr);
`endif
    checkOutput("grant", 32'(grant), 32'(expGrant));
    checkOutput("start", 32'(start), 32'(expStart));
    checkOutput("stage_rst", 32'(stageRst), 32'(expStage(k)));
    checkOutput("busy", 32'(busy), 32'(k < mFree));
    checkOutput("done", 32'(done), 32'(k == evDone));
    checkOutput("err", 32'(err), 32'(expErr));
    checkOutput("last_ch", 32'(lastCh), 32'(mLast));
    for (int i = 0; i < NCH; i++) if (grant[i]) grantLog.push_back(i);
    if (g >= 0) begin
      mLast = g;
      dropPend[g] = 1'b1;
      if (forceLat >= 0) len = forceLat;
      else begin
        len = $urandom % 10;
        len = (len < 6) ? HOPS : (len < 8) ? int'($urandom_range(HOPS - 1, 1)) : 0;
      end
      chainLen[g] = len;
      evStart = k + 1; evStartCh = g;
      if (len == HOPS) begin evDone = k + 2 + HOPS; mFree = evDone; end
      else if (len > 0) begin evErr = k + 2 + len; mFree = evErr; end
      else begin evErr = k + 2 + TMAX; mFree = evErr; end
    end
    k++;
    @(negedge clock0);
  endtask

  task automatic runSeq(input logic [NCH-1:0] r, input int lat, input int cycles);
    forceLat = lat;
    applyStimulus(r, 1'b1, 1'b0);
    cycleCheck();
    for (int i = 1; i < cycles; i++) begin
      applyStimulus('0, 1'b1, 1'b0);
      cycleCheck();
    end
  endtask

  initial begin
    int expOrder [5];
    int got;
    logic [NCH-1:0] raise;
    for (int i = 0; i < NCH; i++) chainLen[i] = HOPS;
    for (int i = 0; i < 4; i++) vecTab[i] = '{i, 5'b11111, 1'b1};
    vecTab[4] = '{4, 5'b11110, 1'b1};
    vecTab[5] = '{5, 5'b11100, 1'b1};
    vecTab[6] = '{6, 5'b11000, 1'b1};
    vecTab[7] = '{7, 5'b10000, 1'b1};
    vecTab[8] = '{8, 5'b00000, 1'b1};
    vecTab[9] = '{9, 5'b00000, 1'b0};
    expOrder = '{0, 1, 2, 3, 0};
    forceLat = HOPS;
    @(negedge clock0);

    // Reset release sequence against hand-written table
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("tab_stage_rst[%0d]", vecTab[i].cyc), 32'(stageRst), 32'({NCH{vecTab[i].hopMask}}));
      checkOutput($sformatf("tab_busy[%0d]", vecTab[i].cyc), 32'(busy), 32'(vecTab[i].busyExp));
      cycleCheck();
    end

    runSeq(4'b0100, HOPS, 12);
    runSeq(4'b0001, 0, 14);
    runSeq(4'b1000, HOPS, 12);
    runSeq(4'b0010, 3, 10);

    // Reset two cycles into a wait must abort silently and restart the release sequence
    forceLat = HOPS;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      cycleCheck();
      if (evStart == k) got = 1;
      applyStimulus('0, 1'b1, 1'b0);
    end
    checkOutput("abort_grant_seen", 32'(got), 32'd1);
    cycleCheck();
    cycleCheck();
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus('0, 1'b1, 1'b0);
      cycleCheck();
    end

    // Round-robin with all requesters re-raising as soon as allowed
    doReset();
    grantLog.delete();
    for (int i = 0; i < 42; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      cycleCheck();
    end
    for (int i = 0; i < 5; i++) begin
      got = (grantLog.size() > i) ? grantLog[i] : -1;
      checkOutput($sformatf("rr_order[%0d]", i), 32'(got), 32'(expOrder[i]));
    end

    // Random traffic
    forceLat = -1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) raise[c] = ($urandom % 4 == 0);
      applyStimulus(raise, ($urandom % 5) != 0, ($urandom % 16) == 0);
      cycleCheck();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
